// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one a_RS232 transmit path between N_REQ word producers; optional tag word precedes each payload.
// First tx_dv_o two cycles after a grantable request; each launch waits for the link busy pulse (or a timeout) before the next.
module rs232_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int TAG_EN       = 1,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [16*N_REQ-1:0]  req_data_i,
    output logic [N_REQ-1:0]     req_ack_o,
    output logic [15:0]          tx_data_o,
    output logic                 tx_dv_o,
    input  logic                 tx_busy_i,
    output logic                 busy_o,
    output logic                 err_timeout_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [IW:0]   NREQ_W   = (IW+1)'(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SEND_TAG, S_SEND_DATA, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   grant_q;
    logic [15:0]     word_q;
    logic            tag_phase_q;
    logic [CW-1:0]   cnt_q;
    logic [N_REQ-1:0] ack_q;
    logic [15:0]     tx_data_q;
    logic            tx_dv_q;
    logic            err_q;

    logic            grant_vld_d;
    logic [IW-1:0]   grant_d;
    logic [IW:0]     sum_d;
    logic [15:0]     word_d;
    logic            step_d;

    // Search starts at the pointer and wraps, so the last-served requester is checked last.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = '0;
        sum_d       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_d = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum_d >= NREQ_W) begin
                sum_d = sum_d - NREQ_W;
            end
            if (!grant_vld_d && req_valid_i[sum_d[IW-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_d     = sum_d[IW-1:0];
            end
        end
    end

    always_comb begin
        word_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_d == IW'(k)) begin
                word_d = req_data_i[16*k +: 16];
            end
        end
    end

    // A launch is finished either when busy falls, or when busy never rose in time.
    assign step_d = ((state_q == S_WAIT_HI) && !tx_busy_i && (cnt_q == CNT_LAST)) ||
                    ((state_q == S_WAIT_LO) && !tx_busy_i);

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            word_q      <= '0;
            tag_phase_q <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= '0;
            tx_data_q   <= '0;
            tx_dv_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q   <= '0;
            tx_dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!tx_busy_i && grant_vld_d) begin
                        state_q <= S_CAPTURE;
                        grant_q <= grant_d;
                        word_q  <= word_d;
                        ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_d;
                    end
                end
                S_CAPTURE: begin
                    ptr_q   <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    tx_dv_q <= 1'b1;
                    if (TAG_EN != 0) begin
                        state_q     <= S_SEND_TAG;
                        tag_phase_q <= 1'b1;
                        tx_data_q   <= {8'hA5, 8'(grant_q)};
                    end else begin
                        state_q     <= S_SEND_DATA;
                        tag_phase_q <= 1'b0;
                        tx_data_q   <= word_q;
                    end
                end
                S_SEND_TAG, S_SEND_DATA: begin
                    state_q <= S_WAIT_HI;
                    cnt_q   <= '0;
                end
                S_WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= S_WAIT_LO;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                end
                default: state_q <= S_IDLE;
            endcase

            if (step_d) begin
                if (tag_phase_q) begin
                    state_q     <= S_SEND_DATA;
                    tag_phase_q <= 1'b0;
                    tx_data_q   <= word_q;
                    tx_dv_q     <= 1'b1;
                end else begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign req_ack_o     = ack_q;
    assign tx_data_o     = tx_data_q;
    assign tx_dv_o       = tx_dv_q;
    assign busy_o        = (state_q != S_IDLE);
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboarded bench for rs232_tx_arbiter with a behavioural a_RS232 busy responder.
module tb_rs232_tx_arbiter;

    logic        clk_ref = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ack_o;
    logic [15:0] tx_data_o;
    logic        tx_dv_o;
    logic        tx_busy;
    logic        busy_o;
    logic        err_timeout_o;

    logic        link_busy;
    logic        link_active;
    logic        link_dead;
    logic        ext_busy;

    int          checks = 0;
    int          errors = 0;
    int          ack_cnt = 0;
    logic [15:0] exp_tx[$];
    int          exp_ack[$];

    assign tx_busy = link_busy | ext_busy;

    always #5 clk_ref = ~clk_ref;

    rs232_tx_arbiter #(.N_REQ(4), .TAG_EN(1), .BUSY_TIMEOUT(15)) dut (
        .clk_ref       (clk_ref),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ack_o     (req_ack_o),
        .tx_data_o     (tx_data_o),
        .tx_dv_o       (tx_dv_o),
        .tx_busy_i     (tx_busy),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [15:0] w);
        req_data[16*k +: 16] = w;
    endtask

    task automatic expect_grant(input int k, input logic [15:0] w, input bit with_data);
        exp_ack.push_back(k);
        exp_tx.push_back({8'hA5, 8'(k)});
        if (with_data) exp_tx.push_back(w);
    endtask

    task automatic wait_ack(input int k, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (!req_ack_o[k] && n < budget);
        check($sformatf("ack_seen_%0d", k), 32'(req_ack_o[k]), 1);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (busy_o && n < budget);
        check(name, 32'(busy_o), 0);
    endtask

    task automatic wait_dv(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (!tx_dv_o && n < budget);
        check(name, 32'(tx_dv_o), 1);
    endtask

    // a_RS232 stand-in: busy rises 2 cycles after a launch and stays up 5 cycles.
    initial begin
        link_busy   = 1'b0;
        link_active = 1'b0;
        forever begin
            @(negedge clk_ref);
            if (tx_dv_o && !link_dead) begin
                #1 link_active = 1'b1;
                repeat (2) @(negedge clk_ref);
                link_busy = 1'b1;
                repeat (5) @(negedge clk_ref);
                link_busy   = 1'b0;
                link_active = 1'b0;
            end
        end
    end

    // Monitor: every ack and every launched word is matched against the scoreboard.
    initial begin
        int idx;
        forever begin
            @(negedge clk_ref);
            if (req_ack_o != 4'b0000) begin
                ack_cnt++;
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", 32'(req_ack_o), 0);
                end else begin
                    idx = exp_ack.pop_front();
                    check("ack_onehot", 32'(req_ack_o), 32'(1) << idx);
                end
            end
            if (tx_dv_o) begin
                check("dv_while_link_busy", 32'(link_active), 0);
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx", 32'(tx_data_o), 32'hFFFF_FFFF);
                end else begin
                    check("tx_word", 32'(tx_data_o), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        link_dead = 1'b0;
        ext_busy  = 1'b0;

        // Reset state
        repeat (4) @(negedge clk_ref);
        check("rst_ack", 32'(req_ack_o), 0);
        check("rst_dv", 32'(tx_dv_o), 0);
        check("rst_data", 32'(tx_data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_timeout_o), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_ref);
        check("idle_no_req", 32'(busy_o), 0);

        // Single request with latency checks
        set_word(2, 16'h4142);
        expect_grant(2, 16'h4142, 1'b1);
        req_valid[2] = 1'b1;
        @(negedge clk_ref);
        check("latency_ack", 32'(req_ack_o), 32'h4);
        req_valid[2] = 1'b0;
        @(negedge clk_ref);
        check("latency_dv", 32'(tx_dv_o), 1);
        check("first_word_tag", 32'(tx_data_o), 32'hA502);
        wait_idle("idle_after_single", 200);
        check("err_after_single", 32'(err_timeout_o), 0);

        // Round-robin with all requesters held valid
        rst = 1'b1;
        @(negedge clk_ref);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_word(k, 16'(k * 16'h1111));
        expect_grant(0, 16'h0000, 1'b1);
        expect_grant(1, 16'h1111, 1'b1);
        expect_grant(2, 16'h2222, 1'b1);
        expect_grant(3, 16'h3333, 1'b1);
        expect_grant(0, 16'h0000, 1'b1);
        base = ack_cnt;
        req_valid = 4'hF;
        n = 0;
        while (ack_cnt < base + 5 && n < 500) begin
            @(negedge clk_ref);
            n++;
        end
        check("rr_ack_count", 32'(ack_cnt - base), 5);
        req_valid = '0;
        wait_idle("idle_after_rr", 200);

        // Fairness wrap: serve 3, then 0 and 3 compete
        set_word(3, 16'h3C3C);
        expect_grant(3, 16'h3C3C, 1'b1);
        req_valid = 4'b1000;
        wait_ack(3, 50);
        wait_idle("idle_after_3", 200);
        set_word(0, 16'h0A0A);
        expect_grant(0, 16'h0A0A, 1'b1);
        expect_grant(3, 16'h3C3C, 1'b1);
        req_valid = 4'b1001;
        wait_ack(0, 50);
        wait_ack(3, 100);
        wait_idle("idle_after_wrap", 200);

        // Busy timeout: link never answers
        link_dead = 1'b1;
        set_word(1, 16'h5A5A);
        expect_grant(1, 16'h5A5A, 1'b1);
        req_valid = 4'b0010;
        wait_ack(1, 50);
        wait_dv("timeout_dv", 10);
        check("err_before_timeout", 32'(err_timeout_o), 0);
        n = 0;
        while (!err_timeout_o && n < 40) begin
            @(negedge clk_ref);
            n++;
        end
        check("timeout_latency", 32'(n), 16);
        wait_idle("idle_after_timeout", 100);
        check("err_sticky", 32'(err_timeout_o), 1);
        link_dead = 1'b0;

        // Reset while waiting for busy
        link_dead = 1'b1;
        set_word(2, 16'h7777);
        expect_grant(2, 16'h7777, 1'b0);
        req_valid = 4'b0100;
        wait_ack(2, 50);
        wait_dv("midop_dv", 10);
        @(negedge clk_ref);
        check("midop_busy", 32'(busy_o), 1);
        rst = 1'b1;
        @(negedge clk_ref);
        check("midop_rst_busy", 32'(busy_o), 0);
        check("midop_rst_dv", 32'(tx_dv_o), 0);
        check("midop_rst_err", 32'(err_timeout_o), 0);
        check("midop_rst_data", 32'(tx_data_o), 0);
        rst = 1'b0;
        link_dead = 1'b0;
        repeat (25) @(negedge clk_ref);
        check("midop_stays_idle", 32'(busy_o), 0);
        set_word(1, 16'hBEEF);
        expect_grant(1, 16'hBEEF, 1'b1);
        req_valid = 4'b0010;
        wait_ack(1, 50);
        wait_idle("idle_after_midop", 200);
        check("err_after_midop", 32'(err_timeout_o), 0);

        // Link owned elsewhere: no grant while busy is high
        ext_busy = 1'b1;
        set_word(0, 16'h1234);
        expect_grant(0, 16'h1234, 1'b1);
        req_valid = 4'b0001;
        repeat (5) @(negedge clk_ref);
        check("ext_busy_no_grant", 32'(busy_o), 0);
        ext_busy = 1'b0;
        wait_ack(0, 20);
        wait_idle("idle_after_ext", 200);

        repeat (5) @(negedge clk_ref);
        check("tx_queue_drained", 32'(exp_tx.size()), 0);
        check("ack_queue_drained", 32'(exp_ack.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
